// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU fetch port (f_*)
// and the load/store port (d_*). One transaction is in flight at a time.
// The memory returns read data MEM_LAT cycles after the m_req cycle.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration on ties.
// When it is not defined, d wins ties by fixed priority.
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-low reset
//   f_req/f_addr     fetch request, held until f_gnt
//   f_gnt            one-cycle accept pulse to fetch
//   f_rvalid/f_rdata fetch response pulse and registered data
//   d_req/d_we/d_addr/d_wdata/d_be  data request payload, held until d_gnt
//   d_gnt            one-cycle accept pulse to data
//   d_rvalid/d_rdata data response pulse (read data or write done), registered data
//   m_req/m_we/m_addr/m_wdata/m_be  memory strobe and payload
//   m_rdata          memory read data, valid MEM_LAT cycles after m_req
//   busy             high whenever the arbiter is not idle
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_req,
    input  logic [AW-1:0]   f_addr,
    output logic            f_gnt,
    output logic            f_rvalid,
    output logic [DW-1:0]   f_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          owner_d;   // 1 = data port owns the transaction
    logic [CW-1:0] cnt;
    logic          win_d_c;
    logic          win_f_c;

`ifdef ARB_RR_EN
    logic last_d;             // port served last; it loses the next tie

    // Round-robin: on a tie the port not served last wins.
    always_comb begin
        win_d_c = 1'b0;
        win_f_c = 1'b0;
        win_d_c = d_req && (!f_req || !last_d);
        win_f_c = f_req && !win_d_c;
    end
`else
    // Fixed priority: data beats fetch.
    always_comb begin
        win_d_c = 1'b0;
        win_f_c = 1'b0;
        win_d_c = d_req;
        win_f_c = f_req && !d_req;
    end
`endif

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            cnt      <= '0;
            f_gnt    <= 1'b0;
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_gnt    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            busy     <= 1'b0;
`ifdef ARB_RR_EN
            last_d   <= 1'b0;
`endif
        end else begin
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            m_req    <= 1'b0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                // Requests are only sampled at the edge that leaves IDLE or RESP.
                IDLE, RESP: begin
                    if (win_d_c || win_f_c) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        owner_d <= win_d_c;
                        f_gnt   <= win_f_c;
                        d_gnt   <= win_d_c;
                        m_req   <= 1'b1;
                        m_addr  <= win_d_c ? d_addr : f_addr;
                        m_we    <= win_d_c && d_we;   // fetch is always a read
                        m_wdata <= win_d_c ? d_wdata : '0;
                        m_be    <= win_d_c ? d_be : {BW{1'b1}};
`ifdef ARB_RR_EN
                        last_d  <= win_d_c;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= CW'(MEM_LAT - 1);
                end
                // Memory payload holds; read data is captured on the last WAIT edge.
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        f_rvalid <= !owner_d;
                        d_rvalid <= owner_d;
                        if (!m_we) begin
                            if (owner_d) begin
                                d_rdata <= m_rdata;
                            end else begin
                                f_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: four mem_arbiter instances (MEM_LAT = 1, 3, 4, 15), each with
// its own request inputs and a fixed-latency memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned NI = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic int unsigned lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return DW'(a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req    [NI];
    logic [AW-1:0] f_addr   [NI];
    logic          f_gnt    [NI];
    logic          f_rvalid [NI];
    logic [DW-1:0] f_rdata  [NI];
    logic          d_req    [NI];
    logic          d_we     [NI];
    logic [AW-1:0] d_addr   [NI];
    logic [DW-1:0] d_wdata  [NI];
    logic [BW-1:0] d_be     [NI];
    logic          d_gnt    [NI];
    logic          d_rvalid [NI];
    logic [DW-1:0] d_rdata  [NI];
    logic          m_req    [NI];
    logic          m_we     [NI];
    logic [AW-1:0] m_addr   [NI];
    logic [DW-1:0] m_wdata  [NI];
    logic [BW-1:0] m_be     [NI];
    logic [DW-1:0] m_rdata  [NI];
    logic          busy     [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic          pend;
        int            cnt;
        logic [AW-1:0] a;

        mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(lat_of(g))) u_dut (
            .clk(clk), .rst(rst),
            .f_req(f_req[g]), .f_addr(f_addr[g]), .f_gnt(f_gnt[g]),
            .f_rvalid(f_rvalid[g]), .f_rdata(f_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_be(d_be[g]), .d_gnt(d_gnt[g]),
            .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .m_req(m_req[g]), .m_we(m_we[g]), .m_addr(m_addr[g]),
            .m_wdata(m_wdata[g]), .m_be(m_be[g]), .m_rdata(m_rdata[g]),
            .busy(busy[g])
        );

        // Memory: data valid only in cycle (m_req cycle + MEM_LAT), junk otherwise.
        initial pend = 1'b0;
        always @(posedge clk) begin
            if (m_req[g]) begin
                if (lat_of(g) == 1) begin
                    m_rdata[g] <= mem_val(m_addr[g]);
                    pend       <= 1'b0;
                end else begin
                    pend       <= 1'b1;
                    cnt        <= int'(lat_of(g)) - 2;
                    a          <= m_addr[g];
                    m_rdata[g] <= {24'hBAD000, 8'($urandom)};
                end
            end else if (pend && cnt == 0) begin
                m_rdata[g] <= mem_val(a);
                pend       <= 1'b0;
            end else begin
                if (pend) cnt <= cnt - 1;
                m_rdata[g] <= {24'hBAD000, 8'($urandom)};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < int'(NI); k++) begin
            f_req[k]   = 1'b0;
            f_addr[k]  = '0;
            d_req[k]   = 1'b0;
            d_we[k]    = 1'b0;
            d_addr[k]  = '0;
            d_wdata[k] = '0;
            d_be[k]    = '0;
        end
    endtask

    // Leaves the bench in cycle 0 just after reset release.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        for (int k = 0; k < int'(NI); k++) begin
            f_req[k]  = 1'b1;
            f_addr[k] = 32'h40;
            d_req[k]  = 1'b1;
            d_addr[k] = 32'h80;
        end
        tick();
        tick();
        for (int k = 0; k < int'(NI); k++) begin
            n_checks++;
            if ({f_gnt[k], d_gnt[k], f_rvalid[k], d_rvalid[k], m_req[k], m_we[k], busy[k]} !== 7'b0
                || f_rdata[k] !== '0 || d_rdata[k] !== '0 || m_addr[k] !== '0
                || m_wdata[k] !== '0 || m_be[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: gnt f/d=%b/%b rv f/d=%b/%b m_req=%b busy=%b f_rdata=%h d_rdata=%h m_addr=%h, required all zero",
                         k, f_gnt[k], d_gnt[k], f_rvalid[k], d_rvalid[k], m_req[k], busy[k], f_rdata[k], d_rdata[k], m_addr[k]);
            end
        end
        rst = 1'b1;
        tick();
        for (int k = 0; k < int'(NI); k++) begin
            n_checks++;
            if (d_gnt[k] !== 1'b1 || f_gnt[k] !== 1'b0 || m_addr[k] !== 32'h80 || busy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_first_grant inst%0d: d_gnt=%b f_gnt=%b m_addr=%h busy=%b, required 1 0 00000080 1",
                         k, d_gnt[k], f_gnt[k], m_addr[k], busy[k]);
            end
        end
        clear_inputs();
        repeat (20) tick();
    endtask

    task automatic test_fetch_read();
        do_reset();
        f_req[0]  = 1'b1;
        f_addr[0] = 32'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (f_gnt[0] !== (c == 1) || m_req[0] !== (c == 1) || f_rvalid[0] !== (c == 3)
                || d_rvalid[0] !== 1'b0 || d_gnt[0] !== 1'b0 || busy[0] !== (c <= 3)) begin
                n_fail++;
                $display("FAIL fetch_read_timing cycle%0d: f_gnt=%b m_req=%b f_rvalid=%b d_rvalid=%b busy=%b, required %b %b %b 0 %b",
                         c, f_gnt[0], m_req[0], f_rvalid[0], d_rvalid[0], busy[0], c == 1, c == 1, c == 3, c <= 3);
            end
            if (c == 1) begin
                f_req[0] = 1'b0;
                n_checks++;
                if (m_addr[0] !== 32'h10 || m_we[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_read_issue: m_addr=%h m_we=%b, required 00000010 0", m_addr[0], m_we[0]);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (f_rdata[0] !== 32'h0050_0093) begin
                    n_fail++;
                    $display("FAIL fetch_read_data: f_rdata=%h, required 00500093", f_rdata[0]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        f_req[0]  = 1'b1;
        f_addr[0] = 32'h20;
        d_req[0]  = 1'b1;
        d_we[0]   = 1'b0;
        d_addr[0] = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_checks++;
            if (d_gnt[0] !== (c == 1) || d_rvalid[0] !== (c == 3)
                || f_gnt[0] !== (c == 4) || f_rvalid[0] !== (c == 6)) begin
                n_fail++;
                $display("FAIL simultaneous_timing cycle%0d: d_gnt=%b d_rvalid=%b f_gnt=%b f_rvalid=%b, required %b %b %b %b",
                         c, d_gnt[0], d_rvalid[0], f_gnt[0], f_rvalid[0], c == 1, c == 3, c == 4, c == 6);
            end
            if (c == 1) d_req[0] = 1'b0;
            if (c == 4) begin
                f_req[0] = 1'b0;
                n_checks++;
                if (m_addr[0] !== 32'h20) begin
                    n_fail++;
                    $display("FAIL simultaneous_f_addr: m_addr=%h, required 00000020", m_addr[0]);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (d_rdata[0] !== mem_val(32'h100) || f_rdata[0] !== mem_val(32'h20)) begin
                    n_fail++;
                    $display("FAIL simultaneous_data: d_rdata=%h f_rdata=%h, required %h %h",
                             d_rdata[0], f_rdata[0], mem_val(32'h100), mem_val(32'h20));
                end
            end
        end
    endtask

    task automatic test_write();
        logic [DW-1:0] prev;
        do_reset();
        d_req[0]  = 1'b1;
        d_addr[0] = 32'h300;
        prev      = mem_val(32'h300);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) d_req[0] = 1'b0;
            if (c == 3) begin
                // Write request raised during RESP of the preceding read.
                d_req[0]   = 1'b1;
                d_we[0]    = 1'b1;
                d_addr[0]  = 32'h200;
                d_wdata[0] = 32'hDEAD_BEEF;
                d_be[0]    = 4'b1111;
            end
            if (c == 4) begin
                d_req[0] = 1'b0;
                n_checks++;
                if (d_gnt[0] !== 1'b1 || m_req[0] !== 1'b1 || m_we[0] !== 1'b1 || m_addr[0] !== 32'h200
                    || m_wdata[0] !== 32'hDEAD_BEEF || m_be[0] !== 4'hF) begin
                    n_fail++;
                    $display("FAIL write_issue: d_gnt=%b m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%h, required 1 1 1 00000200 deadbeef f",
                             d_gnt[0], m_req[0], m_we[0], m_addr[0], m_wdata[0], m_be[0]);
                end
            end
            n_checks++;
            if (d_rvalid[0] !== (c == 3 || c == 6) || f_rvalid[0] !== 1'b0 || f_gnt[0] !== 1'b0
                || (c >= 3 && d_rdata[0] !== prev)) begin
                n_fail++;
                $display("FAIL write_response cycle%0d: d_rvalid=%b f_rvalid=%b d_rdata=%h, required %b 0 %h",
                         c, d_rvalid[0], f_rvalid[0], d_rdata[0], c == 3 || c == 6, prev);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        d_req[2]  = 1'b1;
        d_addr[2] = 32'h80;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) d_req[2] = 1'b0;
        end
        n_checks++;
        if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== mem_val(32'h80)) begin
            n_fail++;
            $display("FAIL midwait_preload: d_rvalid=%b d_rdata=%h, required 1 %h", d_rvalid[2], d_rdata[2], mem_val(32'h80));
        end
        // Fetch sampled at the end of this RESP cycle; reset lands in its third WAIT-side cycle.
        f_req[2]  = 1'b1;
        f_addr[2] = 32'h44;
        tick();
        f_req[2] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({f_gnt[2], d_gnt[2], f_rvalid[2], d_rvalid[2], m_req[2], m_we[2], busy[2]} !== 7'b0
            || f_rdata[2] !== '0 || d_rdata[2] !== '0 || m_addr[2] !== '0 || m_be[2] !== '0) begin
            n_fail++;
            $display("FAIL midwait_async_clear: busy=%b m_addr=%h m_be=%h d_rdata=%h f_rdata=%h, required all zero",
                     busy[2], m_addr[2], m_be[2], d_rdata[2], f_rdata[2]);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            n_checks++;
            if (f_rvalid[2] !== 1'b0 || d_rvalid[2] !== 1'b0 || busy[2] !== 1'b0 || m_req[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL midwait_no_rvalid cycle%0d: f_rvalid=%b d_rvalid=%b busy=%b m_req=%b, required 0 0 0 0",
                         c, f_rvalid[2], d_rvalid[2], busy[2], m_req[2]);
            end
        end
    endtask

    task automatic test_sweep();
        int  k;
        int  per;
        int  j;
        bit  ed;
        bit  ef;
        for (int s = 0; s < 3; s++) begin
            k   = (s == 2) ? 3 : s;
            per = int'(lat_of(k)) + 2;
            do_reset();
            f_req[k]  = 1'b1;
            f_addr[k] = 32'h1000;
            d_req[k]  = 1'b1;
            d_addr[k] = 32'h2000;
            for (int c = 1; c <= 3 * per + 1; c++) begin
                tick();
                ed = 1'b0;
                ef = 1'b0;
                if ((c - 1) % per == 0) begin
                    j  = (c - 1) / per;
                    ed = RR ? (j % 2 == 0) : 1'b1;
                    ef = !ed;
                end
                n_checks++;
                if (f_gnt[k] !== ef || d_gnt[k] !== ed) begin
                    n_fail++;
                    $display("FAIL sweep_grant lat%0d cycle%0d: f_gnt=%b d_gnt=%b, required %b %b",
                             lat_of(k), c, f_gnt[k], d_gnt[k], ef, ed);
                end
            end
            clear_inputs();
            repeat (per + 2) tick();
        end
    endtask

    // Random requesters against a transaction-timeline model: a sample point
    // picks a winner, gnt follows one cycle later and rvalid MEM_LAT+2 cycles
    // after the sample; the next sample is the rvalid cycle itself.
    task automatic test_random(input int k, input int ncyc);
        int            lat;
        int            next_s;
        int            gnt_c;
        int            rv_c;
        bit            own_d;
        bit            rd;
        bit            last_d;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic [DW-1:0] exp_f;
        logic [DW-1:0] exp_d;
        lat    = int'(lat_of(k));
        next_s = 0;
        gnt_c  = -100;
        rv_c   = -100;
        own_d  = 1'b0;
        rd     = 1'b1;
        last_d = 1'b0;
        ad     = '0;
        wd     = '0;
        be     = '0;
        exp_f  = '0;
        exp_d  = '0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            if (c == rv_c && rd) begin
                if (own_d) exp_d = mem_val(ad);
                else       exp_f = mem_val(ad);
            end
            n_checks++;
            if (f_gnt[k] !== (c == gnt_c && !own_d) || d_gnt[k] !== (c == gnt_c && own_d)
                || m_req[k] !== (c == gnt_c)
                || f_rvalid[k] !== (c == rv_c && !own_d) || d_rvalid[k] !== (c == rv_c && own_d)
                || busy[k] !== (c >= gnt_c && c <= rv_c)
                || f_rdata[k] !== exp_f || d_rdata[k] !== exp_d) begin
                n_fail++;
                $display("FAIL random_cycle lat%0d c%0d: gnt f/d=%b/%b m_req=%b rv f/d=%b/%b busy=%b f_rdata=%h d_rdata=%h, required %b/%b %b %b/%b %b %h %h",
                         lat, c, f_gnt[k], d_gnt[k], m_req[k], f_rvalid[k], d_rvalid[k], busy[k], f_rdata[k], d_rdata[k],
                         c == gnt_c && !own_d, c == gnt_c && own_d, c == gnt_c,
                         c == rv_c && !own_d, c == rv_c && own_d, c >= gnt_c && c <= rv_c, exp_f, exp_d);
            end
            if (c >= gnt_c && c < rv_c) begin
                n_checks++;
                if (m_addr[k] !== ad || m_we[k] !== !rd || (own_d && (m_wdata[k] !== wd || m_be[k] !== be))) begin
                    n_fail++;
                    $display("FAIL random_payload lat%0d c%0d: m_addr=%h m_we=%b m_wdata=%h m_be=%h, required %h %b %h %h",
                             lat, c, m_addr[k], m_we[k], m_wdata[k], m_be[k], ad, !rd, wd, be);
                end
            end
            if (c == gnt_c && !own_d) begin
                f_req[k] = 1'b0;
            end else if (!f_req[k] && $urandom_range(0, 3) == 0) begin
                f_req[k]  = 1'b1;
                f_addr[k] = AW'($urandom) & ~AW'(3);
            end
            if (c == gnt_c && own_d) begin
                d_req[k] = 1'b0;
            end else if (!d_req[k] && $urandom_range(0, 3) == 0) begin
                d_req[k]   = 1'b1;
                d_we[k]    = 1'($urandom);
                d_addr[k]  = AW'($urandom) & ~AW'(3);
                d_wdata[k] = DW'($urandom);
                d_be[k]    = BW'($urandom);
            end
            if (c == next_s) begin
                if (f_req[k] || d_req[k]) begin
                    own_d  = d_req[k] && (!RR || !f_req[k] || !last_d);
                    last_d = own_d;
                    if (own_d) begin
                        rd = !d_we[k];
                        ad = d_addr[k];
                        wd = d_wdata[k];
                        be = d_be[k];
                    end else begin
                        rd = 1'b1;
                        ad = f_addr[k];
                    end
                    gnt_c  = c + 1;
                    rv_c   = c + lat + 2;
                    next_s = rv_c;
                end else begin
                    next_s = c + 1;
                end
            end
        end
        clear_inputs();
        repeat (lat + 4) tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_write();
        test_reset_mid_wait();
        test_sweep();
        for (int k = 0; k < int'(NI); k++) begin
            test_random(k, 400);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
